aes128_ecb_dec_iter: RTL and testbench

AES128_ECB_DEC_ITER -- requirements
Module: aes128_ecb_dec_iter

---
 rtl/aes128_ecb_dec_iter_if.sv | 14 +
 rtl/aes128_ecb_dec_iter.sv | 275 +++++++++++++++++++++++++++
 tb/tb_aes128_ecb_dec_iter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_ecb_dec_iter_if.sv
// AXI-Stream style handshake bundle shared by both streaming ports.
// Ports: tdata[W], tkeep[W/8], tvalid, tready, tlast; master/slave modports.
interface axis_if #(
    parameter int W = 32
) ();
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tkeep;
    logic           tvalid;
    logic           tready;
    logic           tlast;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/aes128_ecb_dec_iter.sv
// Iterative AES-128 ECB decryptor: key beats, ct blocks in, pt blocks out.
// Ports: Clk, Rst (sync, high), S_axis (key+ct slave), M_axis (pt master).
// Macro AES128_DEC_KEY_REUSE_EN: keep key across packets until Rst.
module aes_inv_sub_bytes (
    input  logic [127:0] d_i,
    output logic [127:0] d_o
);
    localparam logic [0:255][7:0] ISBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    always_comb begin
        d_o = '0;
        for (int i = 0; i < 16; i++)
            d_o[i*8 +: 8] = ISBOX[d_i[i*8 +: 8]];
    end
endmodule

module aes_inv_shift_rows (
    input  logic [127:0] d_i,
    output logic [127:0] d_o
);
    // Byte 4c+r sits at the MSB end; row r rotates right by r columns.
    always_comb begin
        d_o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                d_o[127-8*(4*c+r) -: 8] = d_i[127-8*(4*((c-r+4)%4)+r) -: 8];
    end
endmodule

module aes_inv_mix_columns (
    input  logic [127:0] d_i,
    output logic [127:0] d_o
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] b2, b4, b8;
        b2 = xt(b);
        b4 = xt(b2);
        b8 = xt(b4);
        return (m[0] ? b : 8'h0) ^ (m[1] ? b2 : 8'h0) ^
               (m[2] ? b4 : 8'h0) ^ (m[3] ? b8 : 8'h0);
    endfunction

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        d_o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = d_i[127-32*c -: 8];
            a1 = d_i[119-32*c -: 8];
            a2 = d_i[111-32*c -: 8];
            a3 = d_i[103-32*c -: 8];
            d_o[127-32*c -: 8] = mul(a0,4'he)^mul(a1,4'hb)^mul(a2,4'hd)^mul(a3,4'h9);
            d_o[119-32*c -: 8] = mul(a0,4'h9)^mul(a1,4'he)^mul(a2,4'hb)^mul(a3,4'hd);
            d_o[111-32*c -: 8] = mul(a0,4'hd)^mul(a1,4'h9)^mul(a2,4'he)^mul(a3,4'hb);
            d_o[103-32*c -: 8] = mul(a0,4'hb)^mul(a1,4'hd)^mul(a2,4'h9)^mul(a3,4'he);
        end
    end
endmodule

module aes_add_round_key (
    input  logic [127:0] d_i,
    input  logic [127:0] k_i,
    output logic [127:0] d_o
);
    assign d_o = d_i ^ k_i;
endmodule

module aes128_ecb_dec_iter #(
    parameter int S_AXIS_WIDTH = 32,
    parameter int M_AXIS_WIDTH = 32
) (
    input logic   Clk,
    input logic   Rst,
    axis_if.slave  S_axis,
    axis_if.master M_axis
);
`ifdef AES128_DEC_KEY_REUSE_EN
    localparam bit KEY_REUSE = 1'b1;
`else
    localparam bit KEY_REUSE = 1'b0;
`endif
    localparam int IN_N  = 128 / S_AXIS_WIDTH;
    localparam int OUT_N = 128 / M_AXIS_WIDTH;
    localparam int ICW   = (IN_N > 1) ? $clog2(IN_N) : 1;
    localparam int OCW   = (OUT_N > 1) ? $clog2(OUT_N) : 1;
    localparam logic [ICW-1:0] ILAST = ICW'(IN_N - 1);
    localparam logic [OCW-1:0] OLAST = OCW'(OUT_N - 1);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    typedef enum logic [4:0] {
        ST_KEY_IN  = 5'b00001,
        ST_KEY_EXP = 5'b00010,
        ST_CT_IN   = 5'b00100,
        ST_ROUND   = 5'b01000,
        ST_PT_OUT  = 5'b10000
    } state_t;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        unique case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [ICW-1:0]   icnt_q, icnt_d, icnt_nx;
    logic [OCW-1:0]   ocnt_q, ocnt_d, ocnt_nx;
    logic [3:0]       rnd_q, rnd_d, ri;
    logic [127:0]     data_q, data_d, k0_q, k0_d, k10_q, k10_d, wk_q, wk_d;
    logic             blast_q, blast_d;
    logic             s_xfer, m_xfer, unused_tkeep;
    logic [127+S_AXIS_WIDTH:0] din_w, kin_w;
    logic [31:0]      sw_in, sw_rot, tmp, f0, f1, f2, f3;
    logic [127:0]     key_fwd, key_inv, isr_o, isb_o, ark_o, imc_o;

    assign unused_tkeep = ^S_axis.tkeep;

    assign S_axis.tready = Rst | (state_q == ST_KEY_IN) | (state_q == ST_CT_IN);
    assign M_axis.tvalid = ~Rst & (state_q == ST_PT_OUT);
    assign M_axis.tdata  = Rst ? '0 : data_q[M_AXIS_WIDTH-1:0];
    assign M_axis.tkeep  = '1;
    assign M_axis.tlast  = M_axis.tvalid & blast_q & (ocnt_q == OLAST);

    assign s_xfer = S_axis.tvalid & S_axis.tready;
    assign m_xfer = M_axis.tvalid & M_axis.tready;

    // Beats enter at the top so the first beat ends up in the LSBs.
    assign din_w = {S_axis.tdata, data_q};
    assign kin_w = {S_axis.tdata, k0_q};
    assign icnt_nx = (icnt_q == ILAST) ? '0 : icnt_q + ICW'(1);
    assign ocnt_nx = (ocnt_q == OLAST) ? '0 : ocnt_q + OCW'(1);

    // One SubWord serves both directions: forward expansion uses w3 of the
    // current key, the inverse step rebuilds w3 of the previous key first.
    assign ri     = (state_q == ST_KEY_EXP) ? rnd_q + 4'd1 : 4'd11 - rnd_q;
    assign sw_in  = (state_q == ST_KEY_EXP) ? wk_q[31:0] : wk_q[31:0] ^ wk_q[63:32];
    assign sw_rot = {sw_in[23:0], sw_in[31:24]};
    assign tmp    = {SBOX[sw_rot[31:24]], SBOX[sw_rot[23:16]],
                     SBOX[sw_rot[15:8]], SBOX[sw_rot[7:0]]} ^ {rcon(ri), 24'h0};
    assign f0 = wk_q[127:96] ^ tmp;
    assign f1 = wk_q[95:64] ^ f0;
    assign f2 = wk_q[63:32] ^ f1;
    assign f3 = wk_q[31:0] ^ f2;
    assign key_fwd = {f0, f1, f2, f3};
    assign key_inv = {wk_q[127:96] ^ tmp, wk_q[95:64] ^ wk_q[127:96],
                      wk_q[63:32] ^ wk_q[95:64], wk_q[31:0] ^ wk_q[63:32]};

    aes_inv_shift_rows  u_isr (.d_i(data_q), .d_o(isr_o));
    aes_inv_sub_bytes   u_isb (.d_i(isr_o), .d_o(isb_o));
    aes_add_round_key   u_ark (.d_i(isb_o), .k_i(key_inv), .d_o(ark_o));
    aes_inv_mix_columns u_imc (.d_i(ark_o), .d_o(imc_o));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_KEY_IN;
            icnt_q  <= '0;
            ocnt_q  <= '0;
            rnd_q   <= '0;
            data_q  <= '0;
            k0_q    <= '0;
            k10_q   <= '0;
            wk_q    <= '0;
            blast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            ocnt_q  <= ocnt_d;
            rnd_q   <= rnd_d;
            data_q  <= data_d;
            k0_q    <= k0_d;
            k10_q   <= k10_d;
            wk_q    <= wk_d;
            blast_q <= blast_d;
        end
    end

    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        ocnt_d  = ocnt_q;
        rnd_d   = rnd_q;
        data_d  = data_q;
        k0_d    = k0_q;
        k10_d   = k10_q;
        wk_d    = wk_q;
        blast_d = blast_q;
        unique case (state_q)
            ST_KEY_IN: begin
                if (s_xfer) begin
                    k0_d   = kin_w[127+S_AXIS_WIDTH:S_AXIS_WIDTH];
                    wk_d   = kin_w[127+S_AXIS_WIDTH:S_AXIS_WIDTH];
                    icnt_d = icnt_nx;
                    if (icnt_q == ILAST) begin
                        state_d = ST_KEY_EXP;
                        rnd_d   = '0;
                    end
                end
            end
            ST_KEY_EXP: begin
                wk_d  = key_fwd;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'd9) begin
                    k10_d   = key_fwd;
                    rnd_d   = '0;
                    state_d = ST_CT_IN;
                end
            end
            ST_CT_IN: begin
                if (s_xfer) begin
                    data_d = din_w[127+S_AXIS_WIDTH:S_AXIS_WIDTH];
                    icnt_d = icnt_nx;
                    if (icnt_q == ILAST) begin
                        blast_d = S_axis.tlast;
                        rnd_d   = '0;
                        state_d = ST_ROUND;
                    end
                end
            end
            ST_ROUND: begin
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'd0) begin
                    data_d = data_q ^ k10_q;
                    wk_d   = k10_q;
                end else begin
                    wk_d = key_inv;
                    if (rnd_q == 4'd10) begin
                        data_d  = ark_o;
                        rnd_d   = '0;
                        state_d = ST_PT_OUT;
                    end else begin
                        data_d = imc_o;
                    end
                end
            end
            ST_PT_OUT: begin
                if (m_xfer) begin
                    data_d = data_q >> M_AXIS_WIDTH;
                    ocnt_d = ocnt_nx;
                    if (ocnt_q == OLAST)
                        state_d = (blast_q && !KEY_REUSE) ? ST_KEY_IN : ST_CT_IN;
                end
            end
            default: state_d = ST_KEY_IN;
        endcase
    end
endmodule

// File: tb/tb_aes128_ecb_dec_iter.sv
// Scoreboard bench: 32/32 DUT for the main flows, 128/8 DUT for width case.
// Expected beats are queued when a block is driven and popped on output.
`timescale 1ns/1ps
module tb_aes128_ecb_dec_iter;
    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct packed { logic [31:0] d; logic l; } b32_t;
    typedef struct packed { logic [7:0] d; logic l; } b8_t;

    logic clk, rst, rst2;
    int   n_cmp = 0;
    int   n_err = 0;
    int   mode = 0;
    int   bi = 0;
    b32_t q32[$];
    b8_t  q8[$];

    axis_if #(.W(32))  s_if ();
    axis_if #(.W(32))  m_if ();
    axis_if #(.W(128)) s2_if ();
    axis_if #(.W(8))   m2_if ();

    aes128_ecb_dec_iter #(.S_AXIS_WIDTH(32), .M_AXIS_WIDTH(32)) dut (
        .Clk(clk), .Rst(rst), .S_axis(s_if), .M_axis(m_if));
    aes128_ecb_dec_iter #(.S_AXIS_WIDTH(128), .M_AXIS_WIDTH(8)) dut2 (
        .Clk(clk), .Rst(rst2), .S_axis(s2_if), .M_axis(m2_if));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                1:       m_if.tready = ~m_if.tready;
                2:       m_if.tready = 1'b0;
                default: m_if.tready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        b32_t e;
        if (bi != 0) chk("tv_mid", m_if.tvalid, 1);
        if (m_if.tvalid && m_if.tready) begin
            if (q32.size() == 0) begin
                chk("spurious", m_if.tvalid, 0);
            end else begin
                e = q32.pop_front();
                chk("pt_beat", m_if.tdata, e.d);
                chk("pt_last", m_if.tlast, e.l);
                chk("tkeep", m_if.tkeep, 4'hf);
                bi = (bi + 1) % 4;
            end
        end
    end

    always @(negedge clk) begin
        b8_t e;
        if (m2_if.tvalid && m2_if.tready) begin
            if (q8.size() == 0) begin
                chk("spurious2", m2_if.tvalid, 0);
            end else begin
                e = q8.pop_front();
                chk("pt8_beat", m2_if.tdata, e.d);
                chk("pt8_last", m2_if.tlast, e.l);
            end
        end
    end

    task automatic send32(input logic [31:0] d, input logic l);
        int   n = 0;
        logic acc = 1'b0;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = s_if.tready;
            @(posedge clk);
            #1;
            n++;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        if (!acc) chk("in_timeout", acc, 1);
    endtask

    task automatic send128(input logic [127:0] d, input logic l);
        int   n = 0;
        logic acc = 1'b0;
        s2_if.tdata  = d;
        s2_if.tlast  = l;
        s2_if.tvalid = 1'b1;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = s2_if.tready;
            @(posedge clk);
            #1;
            n++;
        end
        s2_if.tvalid = 1'b0;
        s2_if.tlast  = 1'b0;
        if (!acc) chk("in2_timeout", acc, 1);
    endtask

    task automatic send_key(input logic [127:0] k);
`ifdef AES128_DEC_KEY_REUSE_EN
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
`endif
        for (int i = 0; i < 4; i++) send32(k[i*32 +: 32], 1'b0);
    endtask

    task automatic send_blk(input logic [127:0] ct, input logic [127:0] pt,
                            input logic last, input logic push);
        b32_t e;
        if (push)
            for (int i = 0; i < 4; i++) begin
                e.d = pt[i*32 +: 32];
                e.l = last && (i == 3);
                q32.push_back(e);
            end
        for (int i = 0; i < 4; i++) send32(ct[i*32 +: 32], last && (i == 3));
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("drain32", q32.size(), 0);
        chk("drain8", q8.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] p;
        b8_t e8;
        int n;
        rst = 1'b1;
        rst2 = 1'b1;
        s_if.tvalid = 1'b0;  s_if.tdata = '0;  s_if.tlast = 1'b0;  s_if.tkeep = '1;
        s2_if.tvalid = 1'b0; s2_if.tdata = '0; s2_if.tlast = 1'b0; s2_if.tkeep = '1;
        m2_if.tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", s_if.tready, 1);
        chk("rst_tvalid", m_if.tvalid, 0);
        chk("rst_tdata", m_if.tdata, 0);
        chk("rst_tlast", m_if.tlast, 0);
        chk("rst2_tready", s2_if.tready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
        chk("post_tready", s_if.tready, 1);
        chk("post_tvalid", m_if.tvalid, 0);
        chk("post_tdata", m_if.tdata, 0);
        chk("post2_tvalid", m2_if.tvalid, 0);
        @(posedge clk);
        #1;

        // 128-bit in, 8-bit out
        p = PT1;
        for (int i = 0; i < 16; i++) begin
            e8.d = p[i*8 +: 8];
            e8.l = (i == 15);
            q8.push_back(e8);
        end
        send128(KEY1, 1'b1);
        send128(CT1, 1'b1);
        drain();

        // single block, with output latency check
        send_key(KEY1);
        send_blk(CT1, PT1, 1'b1, 1'b1);
        repeat (11) begin
            @(negedge clk);
            chk("lat_lo", m_if.tvalid, 0);
        end
        @(negedge clk);
        chk("lat_hi", m_if.tvalid, 1);
        drain();

        // two-block packet
        send_key(KEY2);
        send_blk(CT2, PT2, 1'b0, 1'b1);
        send_blk(CT2, PT2, 1'b1, 1'b1);
        drain();

        // toggling output ready
        mode = 1;
        send_key(KEY1);
        send_blk(CT1, PT1, 1'b1, 1'b1);
        drain();
        mode = 0;
        @(posedge clk);
        #1;

        // next packet: key reloaded unless reuse is built in
`ifndef AES128_DEC_KEY_REUSE_EN
        send_key(KEY1);
`endif
        send_blk(CT1, PT1, 1'b1, 1'b1);
        drain();

        // reset during round 5, then a fresh key
        send_key(KEY2);
        send_blk(CT1, PT1, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tready", s_if.tready, 1);
        chk("mid_rst_tvalid", m_if.tvalid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("aft_rst_tready", s_if.tready, 1);
        chk("aft_rst_tvalid", m_if.tvalid, 0);
        chk("aft_rst_tdata", m_if.tdata, 0);
        chk("aft_rst_tlast", m_if.tlast, 0);
        @(posedge clk);
        #1;
        send_key(KEY1);
        send_blk(CT1, PT1, 1'b1, 1'b1);
        drain();

        // output held under back-pressure
        send_key(KEY2);
        mode = 2;
        send_blk(CT2, PT2, 1'b1, 1'b1);
        n = 0;
        while (!m_if.tvalid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid", m_if.tvalid, 1);
        p = PT2;
        repeat (8) begin
            @(negedge clk);
            chk("bp_data", m_if.tdata, p[31:0]);
            chk("bp_valid_hold", m_if.tvalid, 1);
            chk("bp_in_ready", s_if.tready, 0);
        end
        mode = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
